// File: rtl/vx_mem_credit_sched.sv
// Round-robin memory request scheduler. Each requester has a limit on outstanding
// reads, the requester index is inserted into the tag, and responses are routed back by it.
module vx_mem_credit_sched #(
  parameter int NUM_REQS      = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 32,
  parameter int TAG_IN_WIDTH  = 8,
  parameter int TAG_SEL_IDX   = 0,
  parameter int MAX_PENDING   = 4,
  parameter int DATA_SIZE     = DATA_WIDTH / 8,
  parameter int LOG_NUM_REQS  = $clog2(NUM_REQS),
  parameter int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              req_valid_in,
  input  logic [NUM_REQS-1:0]              req_rw_in,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr_in,
  input  logic [NUM_REQS*DATA_SIZE-1:0]    req_byteen_in,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data_in,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_tag_in,
  output logic [NUM_REQS-1:0]              req_ready_in,
  output logic                             req_valid_out,
  output logic                             req_rw_out,
  output logic [ADDR_WIDTH-1:0]            req_addr_out,
  output logic [DATA_SIZE-1:0]             req_byteen_out,
  output logic [DATA_WIDTH-1:0]            req_data_out,
  output logic [TAG_OUT_WIDTH-1:0]         req_tag_out,
  input  logic                             req_ready_out,
  input  logic                             rsp_valid_in,
  input  logic [TAG_OUT_WIDTH-1:0]         rsp_tag_in,
  input  logic [DATA_WIDTH-1:0]            rsp_data_in,
  output logic                             rsp_ready_in,
  output logic [NUM_REQS-1:0]              rsp_valid_out,
  output logic [NUM_REQS*TAG_IN_WIDTH-1:0] rsp_tag_out,
  output logic [NUM_REQS*DATA_WIDTH-1:0]   rsp_data_out,
  input  logic [NUM_REQS-1:0]              rsp_ready_out,
  output logic                             pending_empty
);
  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  localparam logic [TAG_OUT_WIDTH-1:0] LO_MASK =
    (TAG_OUT_WIDTH'(1) << TAG_SEL_IDX) - TAG_OUT_WIDTH'(1);

  logic [ADDR_WIDTH-1:0]   addr_arr   [NUM_REQS];
  logic [DATA_SIZE-1:0]    byteen_arr [NUM_REQS];
  logic [DATA_WIDTH-1:0]   data_arr   [NUM_REQS];
  logic [TAG_IN_WIDTH-1:0] tag_arr    [NUM_REQS];

  logic [NUM_REQS-1:0]      eligible;
  logic [NUM_REQS-1:0]      cnt_zero;
  logic [LOG_NUM_REQS-1:0]  ptr_reg, ptr_next, win;
  logic                     any_elig, accept;
  logic [TAG_OUT_WIDTH-1:0] tag_ext, tag_ins;
  logic [LOG_NUM_REQS-1:0]  sel;
  logic                     sel_ok, rsp_fire;
  logic [TAG_IN_WIDTH-1:0]  rsp_tag_strip;

  logic                     valid_out_reg, rw_reg;
  logic [ADDR_WIDTH-1:0]    addr_reg;
  logic [DATA_SIZE-1:0]     byteen_reg;
  logic [DATA_WIDTH-1:0]    data_reg;
  logic [TAG_OUT_WIDTH-1:0] tag_reg;

  // The scan runs from the far end back toward ptr, so the index closest to ptr wins.
  always_comb begin
    logic [LOG_NUM_REQS-1:0] idx;
    win      = '0;
    any_elig = 1'b0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      idx = LOG_NUM_REQS'((int'(ptr_reg) + k) % NUM_REQS);
      if (eligible[idx]) begin
        win      = idx;
        any_elig = 1'b1;
      end
    end
  end

  assign accept       = !reset && any_elig && (!valid_out_reg || req_ready_out);
  assign req_ready_in = accept ? (NUM_REQS'(1) << win) : '0;
  assign ptr_next     = accept ? LOG_NUM_REQS'((int'(win) + 1) % NUM_REQS) : ptr_reg;

  // Bits below TAG_SEL_IDX stay in place; the rest move up to make room for the index.
  assign tag_ext = TAG_OUT_WIDTH'(tag_arr[win]);
  assign tag_ins = (tag_ext & LO_MASK) | ((tag_ext & ~LO_MASK) << LOG_NUM_REQS)
                 | (TAG_OUT_WIDTH'(win) << TAG_SEL_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out_reg <= 1'b0;
      ptr_reg       <= '0;
    end else begin
      ptr_reg <= ptr_next;
      if (accept)
        valid_out_reg <= 1'b1;
      else if (req_ready_out)
        valid_out_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rw_reg     <= req_rw_in[win];
      addr_reg   <= addr_arr[win];
      byteen_reg <= byteen_arr[win];
      data_reg   <= data_arr[win];
      tag_reg    <= tag_ins;
    end
  end

  assign req_valid_out  = valid_out_reg;
  assign req_rw_out     = rw_reg;
  assign req_addr_out   = addr_reg;
  assign req_byteen_out = byteen_reg;
  assign req_data_out   = data_reg;
  assign req_tag_out    = tag_reg;

  assign sel           = rsp_tag_in[TAG_SEL_IDX +: LOG_NUM_REQS];
  assign sel_ok        = (int'(sel) < NUM_REQS);
  assign rsp_ready_in  = sel_ok && rsp_ready_out[sel];
  assign rsp_valid_out = (rsp_valid_in && sel_ok) ? (NUM_REQS'(1) << sel) : '0;
  assign rsp_fire      = rsp_valid_in && rsp_ready_in;
  assign rsp_tag_strip = TAG_IN_WIDTH'((rsp_tag_in & LO_MASK)
                       | ((rsp_tag_in >> LOG_NUM_REQS) & ~LO_MASK));

  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_req
    logic [CNT_W-1:0] cnt_reg;
    logic             take, ret;

    assign addr_arr[gi]   = req_addr_in[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign byteen_arr[gi] = req_byteen_in[gi*DATA_SIZE +: DATA_SIZE];
    assign data_arr[gi]   = req_data_in[gi*DATA_WIDTH +: DATA_WIDTH];
    assign tag_arr[gi]    = req_tag_in[gi*TAG_IN_WIDTH +: TAG_IN_WIDTH];

    assign eligible[gi] = req_valid_in[gi] && (req_rw_in[gi] || (cnt_reg < CNT_W'(MAX_PENDING)));
    assign cnt_zero[gi] = (cnt_reg == '0);
    assign take         = accept && (win == LOG_NUM_REQS'(gi)) && !req_rw_in[gi];
    assign ret          = rsp_fire && (sel == LOG_NUM_REQS'(gi));

    // Writes never hold a credit; a take and a return in the same cycle cancel out.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_reg <= '0;
      end else begin
        assert (!(ret && cnt_reg == '0));
        assert (!(take && cnt_reg == CNT_W'(MAX_PENDING)));
        if (take && !ret)
          cnt_reg <= cnt_reg + CNT_W'(1);
        else if (ret && !take && cnt_reg != '0)
          cnt_reg <= cnt_reg - CNT_W'(1);
      end
    end

    assign rsp_tag_out[gi*TAG_IN_WIDTH +: TAG_IN_WIDTH] = rsp_tag_strip;
    assign rsp_data_out[gi*DATA_WIDTH +: DATA_WIDTH]    = rsp_data_in;
  end

  assign pending_empty = (&cnt_zero) && !valid_out_reg;

endmodule

// File: tb/tb_vx_mem_credit_sched.sv
// Scoreboard bench for vx_mem_credit_sched: a reference model predicts grants,
// credits and downstream payloads; scenario tasks add targeted checks.
`timescale 1ns/1ps
module tb_vx_mem_credit_sched;
  localparam int N = 4, DW = 64, AW = 32, TW = 8, MAXP = 4, BE = DW / 8, TOW = TW + 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]     req_valid_in, req_rw_in, req_ready_in;
  logic [N*AW-1:0]  req_addr_in;
  logic [N*BE-1:0]  req_byteen_in;
  logic [N*DW-1:0]  req_data_in;
  logic [N*TW-1:0]  req_tag_in;
  logic             req_valid_out, req_rw_out, req_ready_out;
  logic [AW-1:0]    req_addr_out;
  logic [BE-1:0]    req_byteen_out;
  logic [DW-1:0]    req_data_out;
  logic [TOW-1:0]   req_tag_out;
  logic             rsp_valid_in, rsp_ready_in;
  logic [TOW-1:0]   rsp_tag_in;
  logic [DW-1:0]    rsp_data_in;
  logic [N-1:0]     rsp_valid_out, rsp_ready_out;
  logic [N*TW-1:0]  rsp_tag_out;
  logic [N*DW-1:0]  rsp_data_out;
  logic             pending_empty;

  vx_mem_credit_sched #(
    .NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW),
    .TAG_SEL_IDX(0), .MAX_PENDING(MAXP)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_addr_in(req_addr_in),
    .req_byteen_in(req_byteen_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .req_ready_in(req_ready_in),
    .req_valid_out(req_valid_out), .req_rw_out(req_rw_out), .req_addr_out(req_addr_out),
    .req_byteen_out(req_byteen_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
    .req_ready_out(req_ready_out),
    .rsp_valid_in(rsp_valid_in), .rsp_tag_in(rsp_tag_in), .rsp_data_in(rsp_data_in),
    .rsp_ready_in(rsp_ready_in), .rsp_valid_out(rsp_valid_out), .rsp_tag_out(rsp_tag_out),
    .rsp_data_out(rsp_data_out), .rsp_ready_out(rsp_ready_out),
    .pending_empty(pending_empty)
  );

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [BE-1:0] be;
    logic [DW-1:0] data;
    logic [TOW-1:0] tag;
  } req_t;

  int checks = 0;
  int errors = 0;

  // Requester stimulus: a requester is valid while it has requests left to send.
  int            remaining [N];
  logic          rw_a      [N];
  logic [AW-1:0] addr_a    [N];
  logic [TW-1:0] tag_a     [N];
  logic [N-1:0]  acc_seen;

  // Reference model state, as it will be after the next rising edge.
  int   ptr_m;
  int   pend_m [N];
  req_t exp_q [$];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid_in[i]           = (remaining[i] > 0);
      req_rw_in[i]              = rw_a[i];
      req_addr_in[i*AW +: AW]   = addr_a[i];
      req_byteen_in[i*BE +: BE] = addr_a[i][7:0];
      req_data_in[i*DW +: DW]   = {addr_a[i], ~addr_a[i]};
      req_tag_in[i*TW +: TW]    = tag_a[i];
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] elig, exp_rdy, exp_rv;
    logic [1:0]   sel;
    logic         full, acc, exp_pe;
    int           w, tot;
    req_t         got, e;
    if (reset) begin
      checks++;
      if (req_ready_in !== '0) begin
        errors++;
        $display("FAIL ready_in_during_reset got=%b exp=0000", req_ready_in);
      end
      ptr_m = 0;
      for (int i = 0; i < N; i++) pend_m[i] = 0;
      exp_q.delete();
      acc_seen = '0;
    end else begin
      full = (exp_q.size() != 0);
      tot = 0;
      for (int i = 0; i < N; i++) tot += pend_m[i];
      exp_pe = !full && (tot == 0);
      checks++;
      if (pending_empty !== exp_pe) begin
        errors++;
        $display("FAIL pending_empty got=%b exp=%b", pending_empty, exp_pe);
      end
      checks++;
      if (req_valid_out !== full) begin
        errors++;
        $display("FAIL req_valid_out got=%b exp=%b", req_valid_out, full);
      end else if (full) begin
        got = {req_rw_out, req_addr_out, req_byteen_out, req_data_out, req_tag_out};
        checks++;
        if (got !== exp_q[0]) begin
          errors++;
          $display("FAIL req_payload got=%h exp=%h", got, exp_q[0]);
        end
      end
      if (full && req_ready_out) void'(exp_q.pop_front());

      for (int i = 0; i < N; i++)
        elig[i] = (remaining[i] > 0) && (rw_a[i] || pend_m[i] < MAXP);
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && elig[(ptr_m + k) % N]) w = (ptr_m + k) % N;
      acc = (w >= 0) && (!full || req_ready_out);
      exp_rdy = acc ? (N'(1) << w) : '0;
      checks++;
      if (req_ready_in !== exp_rdy) begin
        errors++;
        $display("FAIL req_ready_in got=%b exp=%b", req_ready_in, exp_rdy);
      end

      sel = rsp_tag_in[1:0];
      exp_rv = rsp_valid_in ? (N'(1) << sel) : '0;
      checks++;
      if (rsp_valid_out !== exp_rv) begin
        errors++;
        $display("FAIL rsp_valid_out got=%b exp=%b", rsp_valid_out, exp_rv);
      end
      checks++;
      if (rsp_ready_in !== rsp_ready_out[sel]) begin
        errors++;
        $display("FAIL rsp_ready_in got=%b exp=%b", rsp_ready_in, rsp_ready_out[sel]);
      end
      if (rsp_valid_in) begin
        checks++;
        if (rsp_tag_out[sel*TW +: TW] !== rsp_tag_in[TOW-1:2] ||
            rsp_data_out[sel*DW +: DW] !== rsp_data_in) begin
          errors++;
          $display("FAIL rsp_route tag got=%h exp=%h data got=%h exp=%h",
                   rsp_tag_out[sel*TW +: TW], rsp_tag_in[TOW-1:2],
                   rsp_data_out[sel*DW +: DW], rsp_data_in);
        end
      end

      if (acc) begin
        e.rw   = rw_a[w];
        e.addr = addr_a[w];
        e.be   = addr_a[w][7:0];
        e.data = {addr_a[w], ~addr_a[w]};
        e.tag  = {tag_a[w], 2'(w)};
        exp_q.push_back(e);
        ptr_m = (w + 1) % N;
        if (!rw_a[w]) pend_m[w]++;
      end
      if (rsp_valid_in && rsp_ready_out[sel] && pend_m[sel] > 0) pend_m[sel]--;
      acc_seen = req_ready_in & req_valid_in;
    end
  end

  function automatic bit any_remaining();
    bit r = 1'b0;
    for (int i = 0; i < N; i++) if (remaining[i] > 0) r = 1'b1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc_seen[i]) begin
        remaining[i]--;
        addr_a[i] += 32'h10;
      end
  endtask

  task automatic drain();
    int c = 0;
    int busy;
    rsp_ready_out = '1;
    while (c < 200) begin
      busy = -1;
      for (int i = N - 1; i >= 0; i--) if (pend_m[i] > 0) busy = i;
      if (busy < 0 && !any_remaining()) break;
      if (busy >= 0) begin
        rsp_valid_in = 1'b1;
        rsp_tag_in   = {tag_a[busy], 2'(busy)};
        rsp_data_in  = {$urandom(), $urandom()};
      end
      step();
      rsp_valid_in = 1'b0;
      c++;
    end
    checks++;
    if (c >= 200) begin
      errors++;
      $display("FAIL drain_timeout cycles=%0d limit=200", c);
    end
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_valid_out !== 1'b0 || pending_empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_state valid_out=%b pending_empty=%b exp=0/1", req_valid_out, pending_empty);
    end
    step();
  endtask

  task automatic test_fairness();
    int grants [$];
    int c = 0;
    for (int i = 0; i < N; i++) begin
      rw_a[i] = 1'b0; tag_a[i] = 8'h10 + 8'(i); addr_a[i] = 32'h1000 * (i + 1); remaining[i] = 3;
    end
    while (any_remaining() && c < 40) begin
      step();
      c++;
      for (int i = 0; i < N; i++) if (acc_seen[i]) grants.push_back(i);
    end
    checks++;
    if (grants.size() != 12) begin
      errors++;
      $display("FAIL fairness_count got=%0d exp=12", grants.size());
    end
    for (int k = 0; k < grants.size(); k++) begin
      checks++;
      if (grants[k] != k % N) begin
        errors++;
        $display("FAIL fairness_order idx=%0d got=%0d exp=%0d", k, grants[k], k % N);
      end
    end
    drain();
  endtask

  task automatic test_credit_stall();
    rw_a[1] = 1'b0; tag_a[1] = 8'h21; remaining[1] = MAXP + 1;
    repeat (8) step();
    checks++;
    if (remaining[1] != 1) begin
      errors++;
      $display("FAIL credit_stall_accepts left=%0d exp=1", remaining[1]);
    end
    rsp_valid_in = 1'b1;
    rsp_tag_in   = {8'h21, 2'd1};
    rsp_data_in  = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    checks++;
    if (req_ready_in[1] !== 1'b0) begin
      errors++;
      $display("FAIL credit_no_bypass got=%b exp=0", req_ready_in[1]);
    end
    step();
    rsp_valid_in = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready_in !== 4'b0010) begin
      errors++;
      $display("FAIL credit_return_accept got=%b exp=0010", req_ready_in);
    end
    step();
    drain();
  endtask

  task automatic test_write_bypass();
    rw_a[0] = 1'b0; tag_a[0] = 8'h33; remaining[0] = MAXP;
    repeat (6) step();
    rw_a[0] = 1'b1; remaining[0] = 1;
    @(negedge clk);
    checks++;
    if (req_ready_in !== 4'b0001) begin
      errors++;
      $display("FAIL write_bypass got=%b exp=0001", req_ready_in);
    end
    step();
    rw_a[0] = 1'b0; remaining[0] = 1;
    step();
    @(negedge clk);
    checks++;
    if (req_ready_in !== 4'b0000) begin
      errors++;
      $display("FAIL write_no_credit got=%b exp=0000", req_ready_in);
    end
    step();
    drain();
  endtask

  task automatic test_back_to_back_backpressure();
    int accepts = 0;
    int g1 = -1;
    int g2 = -1;
    req_ready_out = 1'b0;
    rw_a[2] = 1'b1; rw_a[3] = 1'b1; remaining[2] = 3; remaining[3] = 3;
    repeat (5) begin
      step();
      for (int i = 0; i < N; i++) if (acc_seen[i]) begin accepts++; if (g1 < 0) g1 = i; end
    end
    checks++;
    if (accepts != 1) begin
      errors++;
      $display("FAIL backpressure_accepts got=%0d exp=1", accepts);
    end
    req_ready_out = 1'b1;
    step();
    for (int i = 0; i < N; i++) if (acc_seen[i]) g2 = i;
    checks++;
    if (g2 != (g1 == 2 ? 3 : 2)) begin
      errors++;
      $display("FAIL backpressure_ptr got=%0d exp=%0d", g2, (g1 == 2 ? 3 : 2));
    end
    drain();
  endtask

  task automatic test_rsp_routing();
    rw_a[2] = 1'b0; tag_a[2] = 8'h5A; remaining[2] = 1;
    repeat (3) step();
    rsp_ready_out = 4'b1011;
    rsp_valid_in  = 1'b1;
    rsp_tag_in    = {8'h5A, 2'd2};
    rsp_data_in   = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    checks++;
    if (rsp_valid_out !== 4'b0100 || rsp_tag_out[23:16] !== 8'h5A || rsp_ready_in !== 1'b0) begin
      errors++;
      $display("FAIL rsp_routing valid=%b tag=%h ready=%b exp=0100/5a/0",
               rsp_valid_out, rsp_tag_out[23:16], rsp_ready_in);
    end
    step();
    rsp_valid_in  = 1'b0;
    rsp_ready_out = '1;
    repeat (2) step();
    @(negedge clk);
    checks++;
    if (pending_empty !== 1'b0) begin
      errors++;
      $display("FAIL rsp_not_ready_kept_credit pending_empty=%b exp=0", pending_empty);
    end
    remaining[2] = 1;
    rsp_valid_in = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready_in !== 4'b0100 || rsp_ready_in !== 1'b1) begin
      errors++;
      $display("FAIL simultaneous_take_return ready_in=%b rsp_ready=%b exp=0100/1", req_ready_in, rsp_ready_in);
    end
    step();
    rsp_valid_in = 1'b0;
    remaining[2] = MAXP;
    repeat (8) step();
    checks++;
    if (remaining[2] != 1) begin
      errors++;
      $display("FAIL simultaneous_count left=%0d exp=1", remaining[2]);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int grants [$];
    int c = 0;
    for (int i = 0; i < N; i++) rw_a[i] = 1'b0;
    remaining[0] = 2; remaining[1] = 1; remaining[2] = 0; remaining[3] = 3;
    while (any_remaining() && c < 20) begin step(); c++; end
    req_ready_out = 1'b0;
    @(negedge clk);
    checks++;
    if (req_valid_out !== 1'b1 || pending_empty !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_setup valid_out=%b pending_empty=%b exp=1/0", req_valid_out, pending_empty);
    end
    step();
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin rw_a[i] = 1'b1; remaining[i] = 1; end
    repeat (2) step();
    reset = 1'b0;
    req_ready_out = 1'b1;
    @(negedge clk);
    checks++;
    if (req_valid_out !== 1'b0 || pending_empty !== 1'b1 || req_ready_in !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid valid_out=%b pending_empty=%b ready_in=%b exp=0/1/0001",
               req_valid_out, pending_empty, req_ready_in);
    end
    c = 0;
    while (any_remaining() && c < 20) begin
      step();
      c++;
      for (int i = 0; i < N; i++) if (acc_seen[i]) grants.push_back(i);
    end
    for (int k = 0; k < grants.size(); k++) begin
      checks++;
      if (grants[k] != k) begin
        errors++;
        $display("FAIL reset_mid_order idx=%0d got=%0d exp=%0d", k, grants[k], k);
      end
    end
    repeat (3) step();
  endtask

  initial begin
    reset         = 1'b1;
    acc_seen      = '0;
    req_ready_out = 1'b1;
    rsp_valid_in  = 1'b0;
    rsp_tag_in    = '0;
    rsp_data_in   = '0;
    rsp_ready_out = '1;
    for (int i = 0; i < N; i++) begin
      remaining[i] = 0; rw_a[i] = 1'b0; addr_a[i] = 32'h100 * (i + 1); tag_a[i] = 8'(i);
    end
    test_reset();
    test_fairness();
    test_credit_stall();
    test_write_bypass();
    test_back_to_back_backpressure();
    test_rsp_routing();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
